// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle controller: FSM states, opcodes, ALU
// operation codes and ALU B-operand select values.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WR   = 4'd4,
      WB_MEM   = 4'd5,
      EXEC_R   = 4'd6,
      EXEC_I   = 4'd7,
      WB_ALU   = 4'd8,
      BRANCH   = 4'd9,
      ILLEGAL  = 4'd10
   } ctrl_state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_OR  = 4'b0011,
      ALU_XOR = 4'b0100,
      ALU_SLT = 4'b0101,
      ALU_SLL = 4'b0110,
      ALU_SRL = 4'b0111
   } alu_op_e;

   typedef enum logic [1:0] {
      SRC_B_RS2  = 2'd0,
      SRC_B_IMM  = 2'd1,
      SRC_B_FOUR = 2'd2
   } alu_src_b_e;

endpackage

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Maps funct3/funct7 to an ALU operation. funct7[5] turns ADD into SUB for
// register-register instructions only; immediates never subtract.
module alu_op_decode
   import ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_rtype,
   output alu_op_e    alu_op
);

   always_comb begin
      alu_op = ALU_ADD;
      case (funct3)
         3'b000:  alu_op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_op = ALU_SLL;
         3'b010:  alu_op = ALU_SLT;
         3'b011:  alu_op = ALU_SLT;   // unsigned compare folded onto SLT
         3'b100:  alu_op = ALU_XOR;
         3'b101:  alu_op = ALU_SRL;
         3'b110:  alu_op = ALU_OR;
         3'b111:  alu_op = ALU_AND;
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (fetch/decode/memory/execute/writeback/branch).
// Define MCTRL_PERF_EN to add the cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_write,
   output logic        adr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  alu_op,
   output logic        mem_to_reg,
   output logic        trap,
   output logic [3:0]  state_dbg
`ifdef MCTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
`endif
);

   ctrl_state_e state_q, state_d;
   alu_op_e     dec_op;
   logic [6:0]  opcode;
   logic        unused_instr;

   assign opcode       = instr[6:0];
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
   assign state_dbg    = state_q;

   alu_op_decode u_alu_op_decode (
      .funct3   (instr[14:12]),
      .funct7_5 (instr[30]),
      .is_rtype (state_q == EXEC_R),
      .alu_op   (dec_op)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRC_B_RS2;
      alu_op     = ALU_ADD;
      mem_to_reg = 1'b0;
      trap       = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = SRC_B_FOUR;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = DECODE;
            end
         end
         DECODE: begin
            case (opcode)
               OPC_LOAD, OPC_STORE: state_d = MEM_ADDR;
               OPC_RTYPE:           state_d = EXEC_R;
               OPC_ITYPE:           state_d = EXEC_I;
               OPC_BRANCH:          state_d = BRANCH;
               default:             state_d = ILLEGAL;
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
            state_d   = (opcode == OPC_STORE) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_d = WB_MEM;
         end
         MEM_WR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready) state_d = FETCH;
         end
         WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = FETCH;
         end
         EXEC_R: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_RS2;
            alu_op    = dec_op;
            state_d   = WB_ALU;
         end
         EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
            alu_op    = dec_op;
            state_d   = WB_ALU;
         end
         WB_ALU: begin
            reg_write = 1'b1;
            state_d   = FETCH;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_SUB;
            pc_write  = zero;
            state_d   = FETCH;
         end
         ILLEGAL: begin
            trap = 1'b1;
         end
         default: state_d = FETCH;
      endcase
      // The fetch pulse is combinational on mem_ready; keep it quiet while held in reset.
      if (reset) begin
         ir_write = 1'b0;
         pc_write = 1'b0;
      end
   end

`ifdef MCTRL_PERF_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] instret_cnt_q, instret_cnt_d;

   always_comb begin
      cycle_cnt_d   = cycle_cnt_q + 32'd1;
      instret_cnt_d = instret_cnt_q;
      if (state_q != FETCH && state_d == FETCH) instret_cnt_d = instret_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt_q   <= 32'd0;
         instret_cnt_q <= 32'd0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         instret_cnt_q <= instret_cnt_d;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port instr, input, 32, current instruction-register contents.
REQ-004 SHALL have port zero, input, 1, ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1, memory accepts or completes the access this cycle.
REQ-006 SHALL have port mem_req, output, 1, memory access request.
REQ-007 SHALL have port mem_write, output, 1, access is a store; valid only with mem_req.
REQ-008 SHALL have port adr_src, output, 1, memory address select: 0 = PC, 1 = ALU result register.
REQ-009 SHALL have ports ir_write, pc_write, reg_write, output, 1 each, register enables.
REQ-010 SHALL have ports alu_src_a, output, 1 (0 = PC, 1 = rs1), and alu_src_b, output, 2 (0 = rs2, 1 = imm, 2 = constant 4).
REQ-011 SHALL have port alu_op, output, 4, ALU operation encoded per ctrl_pkg.
REQ-012 SHALL have port mem_to_reg, output, 1, writeback source: 1 = memory data, 0 = ALU.
REQ-013 SHALL have port trap, output, 1, sticky illegal-opcode flag.

Function
REQ-014 SHALL implement states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, EXEC_R, EXEC_I, WB_ALU, BRANCH and ILLEGAL.
REQ-015 FETCH: mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=2, alu_op=ADD; when mem_ready=1, pulse ir_write and pc_write and go to DECODE; otherwise hold FETCH with all outputs unchanged.
REQ-016 DECODE (1 cycle): decode instr[6:0]: 0000011 and 0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; any other value -> ILLEGAL.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=1, alu_op=ADD; go to MEM_RD for a load or MEM_WR for a store.
REQ-018 MEM_RD: mem_req=1, adr_src=1, mem_write=0; wait for mem_ready, then go to WB_MEM.
REQ-019 MEM_WR: mem_req=1, mem_write=1, adr_src=1; wait for mem_ready, then go to FETCH.
REQ-020 WB_MEM: reg_write=1, mem_to_reg=1; then go to FETCH.
REQ-021 EXEC_R/EXEC_I: alu_src_a=1; alu_src_b=0 (R) or 1 (I); alu_op from funct3/funct7 (funct7[5] selects SUB only for R-type); then go to WB_ALU.
REQ-022 WB_ALU: reg_write=1, mem_to_reg=0; then go to FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB; pc_write=zero; then go to FETCH.
REQ-024 ILLEGAL: trap=1; all enables and mem_req=0; the FSM stays in ILLEGAL until reset.
REQ-025 With zero-wait memory, latency SHALL be: load 5 cycles, store 4, R-type/I-type 4, branch 3.
REQ-026 In every state, any enable not listed for that state SHALL be 0; mem_req SHALL never deassert before mem_ready is sampled high.
REQ-027 Outputs SHALL be Moore outputs, except pc_write in BRANCH and the ir_write/pc_write pulse in FETCH, which are combinational on zero/mem_ready.

Reset
REQ-028 Reset assertion SHALL force FETCH asynchronously, including during a pending memory wait; the pending request is abandoned.
REQ-029 During reset, all outputs SHALL be 0, except mem_req=1 and alu_src_b=2 (FETCH Moore values), and trap SHALL be cleared.

Configuration
REQ-030 With MCTRL_PERF_EN defined, the block SHALL add outputs cycle_cnt[31:0] (increments every non-reset cycle) and instret_cnt[31:0] (increments on each transition into FETCH from any non-reset state); both reset to 0 and wrap modulo 2^32.
REQ-031 Without MCTRL_PERF_EN, these ports and counters SHALL be absent.

Structure
REQ-032 Package ctrl_pkg SHALL hold the state enum, opcode constants, the alu_op encoding (ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLL=0110, SRL=0111) and the alu_src_b encoding.
REQ-033 The funct3/funct7-to-alu_op mapping SHALL live in sub-module alu_op_decode, instantiated once.

Verification
REQ-034 lw, mem_ready tied to 1 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, WB_MEM; reg_write=1 and mem_to_reg=1 in cycle 5 only.
REQ-035 sw with mem_ready low for 3 cycles in MEM_WR -> mem_req=1 and mem_write=1 held for 4 cycles; reg_write never asserted; FSM returns to FETCH.
REQ-036 add x1,x2,x3 (0x003100B3) -> in EXEC_R, alu_op=0000 and alu_src_b=0; sub (funct7=0100000) -> alu_op=0001.
REQ-037 beq with zero=1 -> pc_write=1 in BRANCH; beq with zero=0 -> pc_write=0; both take 3 cycles.
REQ-038 Opcode 0x7F -> ILLEGAL with trap=1 that persists for 10+ cycles; reset asserted mid-wait in MEM_RD -> FETCH immediately, with trap=0.
